// File: rtl/letc_core_muldiv.sv
// letc_core_muldiv: iterative RV32M multiply/divide unit.
//   Shift-add multiply and restoring divide on operand magnitudes. The sign
//   is applied to the final value. BITS_PER_CYCLE bits are retired per
//   iteration.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_flush           abort any in-flight op and discard its result
//   i_valid/o_ready   request handshake; i_op = funct3, i_operands[0]=rs1, [1]=rs2
//   o_valid/i_ready   response handshake; o_result holds the result
module letc_core_muldiv #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [2:0]               i_op,
  input  logic [1:0][XLEN-1:0]     i_operands,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [XLEN-1:0]          o_result
);

  localparam int ITERS = XLEN / BITS_PER_CYCLE;
  localparam int CW    = $clog2(ITERS + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [2:0]          op_q;
  logic                neg;
  // Multiply: shf = multiplier (shifts right), opd = multiplicand (shifts left),
  //           acc = product accumulator.
  // Divide:   shf = dividend shifting out / quotient shifting in,
  //           opd = divisor, acc[XLEN-1:0] = partial remainder.
  logic [XLEN-1:0]     shf;
  logic [2*XLEN-1:0]   opd;
  logic [2*XLEN-1:0]   acc;

  // Request decode.
  logic [XLEN-1:0] a, b, ma, mb, spec_res;
  logic            a_sgn, b_sgn, sa, sb, div_zero, div_ovf, req_neg;

  always_comb begin
    a        = i_operands[0];
    b        = i_operands[1];
    a_sgn    = (i_op == 3'd1) || (i_op == 3'd2) || (i_op == 3'd4) || (i_op == 3'd6);
    b_sgn    = (i_op == 3'd1) || (i_op == 3'd4) || (i_op == 3'd6);
    sa       = a_sgn & a[XLEN-1];
    sb       = b_sgn & b[XLEN-1];
    // Negating the most-negative value wraps to 2^(XLEN-1), which is the
    // correct unsigned magnitude.
    ma       = sa ? -a : a;
    mb       = sb ? -b : b;
    // A remainder takes the dividend's sign. Every other result takes the
    // xor of the two signs. MUL and MULHU have both signs cleared.
    req_neg  = (i_op[2] & i_op[1]) ? sa : (sa ^ sb);
    div_zero = i_op[2] && (b == '0);
    div_ovf  = ((i_op == 3'd4) || (i_op == 3'd6)) &&
               (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    spec_res = '0;
    if (div_zero)     spec_res = i_op[1] ? a : '1;
    else if (div_ovf) spec_res = i_op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // One iteration, unrolled over BITS_PER_CYCLE bits.
  logic [2*XLEN-1:0] nxt_acc, nxt_opd;
  logic [XLEN-1:0]   nxt_shf;
  logic [XLEN:0]     rem_try;

  always_comb begin
    nxt_acc = acc;
    nxt_opd = opd;
    nxt_shf = shf;
    rem_try = '0;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      if (!op_q[2]) begin
        if (nxt_shf[0]) nxt_acc = nxt_acc + nxt_opd;
        nxt_opd = nxt_opd << 1;
        nxt_shf = nxt_shf >> 1;
      end else begin
        rem_try = {nxt_acc[XLEN-1:0], nxt_shf[XLEN-1]};
        nxt_shf = nxt_shf << 1;
        if (rem_try >= {1'b0, opd[XLEN-1:0]}) begin
          rem_try    = rem_try - {1'b0, opd[XLEN-1:0]};
          nxt_shf[0] = 1'b1;
        end
        nxt_acc[XLEN-1:0] = rem_try[XLEN-1:0];
      end
    end
  end

  // Sign correction of the final value, taken from this cycle's iteration output.
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rmd_mag, rmd, fin_res;

  always_comb begin
    prod    = neg ? -nxt_acc : nxt_acc;
    quo     = neg ? -nxt_shf : nxt_shf;
    rmd_mag = nxt_acc[XLEN-1:0];
    rmd     = neg ? -rmd_mag : rmd_mag;
    if (op_q[2])              fin_res = op_q[1] ? rmd : quo;
    else if (op_q[1:0] == '0) fin_res = prod[XLEN-1:0];
    else                      fin_res = prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= S_IDLE;
      o_ready  <= 1'b1;
      o_valid  <= 1'b0;
      o_result <= '0;
      cnt      <= '0;
      op_q     <= '0;
      neg      <= 1'b0;
      shf      <= '0;
      opd      <= '0;
      acc      <= '0;
    end else if (i_flush) begin
      state   <= S_IDLE;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (i_valid) begin
          op_q    <= i_op;
          neg     <= req_neg;
          acc     <= '0;
          shf     <= i_op[2] ? ma : mb;
          opd     <= {{XLEN{1'b0}}, (i_op[2] ? mb : ma)};
          o_ready <= 1'b0;
          if (div_zero || div_ovf) begin
            o_result <= spec_res;
            o_valid  <= 1'b1;
            state    <= S_DONE;
          end else begin
            cnt   <= CW'(ITERS);
            state <= S_BUSY;
          end
        end
        S_BUSY: begin
          acc <= nxt_acc;
          opd <= nxt_opd;
          shf <= nxt_shf;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            o_result <= fin_res;
            o_valid  <= 1'b1;
            state    <= S_DONE;
          end
        end
        S_DONE: if (i_ready) begin
          o_valid <= 1'b0;
          o_ready <= 1'b1;
          state   <= S_IDLE;
        end
        default: begin
          state   <= S_IDLE;
          o_ready <= 1'b1;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_letc_core_muldiv.sv
// Bench for letc_core_muldiv. It drives four instances in lockstep, with
// BITS_PER_CYCLE = 1, 2, 4 and 8. Each result is compared against an
// arithmetic reference model. Latency is counted in clocks after the
// accept edge.
module tb_letc_core_muldiv;

  logic        i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic             i_rst, i_flush, i_valid, i_ready;
  logic [2:0]       i_op;
  logic [1:0][31:0] i_operands;
  logic [3:0]       o_ready, o_valid;
  logic [31:0]      o_result [4];

  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    letc_core_muldiv #(.XLEN(32), .BITS_PER_CYCLE(1 << g)) dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_flush    (i_flush),
      .i_valid    (i_valid),
      .o_ready    (o_ready[g]),
      .i_op       (i_op),
      .i_operands (i_operands),
      .o_valid    (o_valid[g]),
      .i_ready    (i_ready),
      .o_result   (o_result[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && ((b == 0) || ((op == 4 || op == 6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int          ia, ib;
    longint      la, lb;
    ia = a; ib = b;
    la = ia; lb = ib;
    case (op)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = la * lb; return p[63:32]; end
      3'd2: begin lb = longint'({32'b0, b}); p = la * lb; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (is_special(op, a, b)) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (is_special(op, a, b)) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Called at a negedge. Returns at the negedge after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    i_valid       = 1'b1;
    i_op          = op;
    i_operands[0] = a;
    i_operands[1] = b;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int hold);
    int lat [4];
    int want;
    for (int g = 0; g < 4; g++) lat[g] = 0;
    issue(op, a, b);
    for (int c = 1; c <= 60; c++) begin
      for (int g = 0; g < 4; g++) if (o_valid[g] && lat[g] == 0) lat[g] = c;
      if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0 && lat[3] != 0) break;
      @(negedge i_clk);
    end
    for (int g = 0; g < 4; g++) begin
      want = is_special(op, a, b) ? 1 : 32 / (1 << g) + 1;
      chk($sformatf("result op%0d bpc%0d", op, 1 << g), o_result[g], exp);
      chk($sformatf("latency op%0d bpc%0d", op, 1 << g), 32'(lat[g]), 32'(want));
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge i_clk);
      chk("hold_result", o_result[0], exp);
      chk("hold_ready", 32'(o_ready), 32'h0);
      chk("hold_valid", 32'(o_valid), 32'hF);
    end
    i_ready = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_ready = 1'b0;
    chk("idle_ready", 32'(o_ready), 32'hF);
    chk("idle_valid", 32'(o_valid), 32'h0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      4:       return -32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [3:0]  seen;
    logic [2:0]  op;
    logic [31:0] a, b;

    i_rst = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_op = '0; i_operands = '0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_ready", 32'(o_ready), 32'hF);
    chk("rst_valid", 32'(o_valid), 32'h0);
    for (int g = 0; g < 4; g++) chk("rst_result", o_result[g], 32'h0);
    i_rst = 1'b0;
    @(negedge i_clk);

    // Directed multiply and divide cases.
    do_op(3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 10);
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 0);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 0);
    do_op(3'd5, 32'd100,      32'd7,        32'd14,        0);
    do_op(3'd7, 32'd100,      32'd7,        32'd2,         0);
    // Special divide cases.
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         0);
    do_op(3'd4, 32'd5,        32'd0,        32'hFFFF_FFFF, 0);
    do_op(3'd6, 32'd5,        32'd0,        32'd5,         0);

    // Flush a DIV in flight. A request offered in the flush cycle must be dropped.
    issue(3'd4, 32'd1234567, 32'd89);
    @(negedge i_clk);
    i_flush = 1'b1;
    i_valid = 1'b1; i_op = 3'd5; i_operands[0] = 32'd9; i_operands[1] = 32'd0;
    @(posedge i_clk);
    @(negedge i_clk);
    i_flush = 1'b0; i_valid = 1'b0;
    chk("flush_ready", 32'(o_ready), 32'hF);
    chk("flush_valid", 32'(o_valid), 32'h0);
    for (int g = 0; g < 4; g++) chk("flush_hold_result", o_result[g], 32'd5);
    seen = '0;
    repeat (40) begin @(negedge i_clk); seen |= o_valid; end
    chk("flush_no_valid", 32'(seen), 32'h0);

    // Reset in the middle of BUSY.
    issue(3'd0, 32'd3, 32'd5);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("midrst_ready", 32'(o_ready), 32'hF);
    chk("midrst_valid", 32'(o_valid), 32'h0);
    for (int g = 0; g < 4; g++) chk("midrst_result", o_result[g], 32'h0);
    seen = '0;
    repeat (40) begin @(negedge i_clk); seen |= o_valid; end
    chk("midrst_no_valid", 32'(seen), 32'h0);

    // Random ops against the reference model.
    for (int n = 0; n < 150; n++) begin
      op = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      do_op(op, a, b, model(op, a, b), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
